// File: rtl/rr_bus_arbiter_8_if.sv
// Purpose: bundles the eight-requester input side and the shared output channel of rr_bus_arbiter_8.
// Latency: none (signal container only).
// Backpressure: carries in_ready/out_ready; the arbiter routes out_ready to the granted requester only.
// Ports: in_req/in_data/in_last/out_ready come from the environment; in_ready/out_*/gnt/gnt_id/busy come from the arbiter.
interface rr_bus_arbiter_8_if #(
    parameter int WIDTH = 16
);
    logic [7:0]         in_req;
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_last;
    logic [7:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic               out_ready;
    logic [7:0]         gnt;
    logic [2:0]         gnt_id;
    logic               busy;

    // Environment side: drives requests and downstream ready.
    modport master (
        output in_req, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, gnt, gnt_id, busy
    );

    // Arbiter side.
    modport slave (
        input  in_req, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, gnt, gnt_id, busy
    );
endinterface

// File: rtl/rr_bus_arbiter_8.sv
// Purpose: round-robin arbiter granting one of eight requesters the output channel for a whole packet.
// Latency: grant registered one edge after a request is seen in IDLE; data path is combinational, zero added latency.
// Backpressure: out_ready passes combinationally to in_ready of the granted requester only; others see 0.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries in_req/in_data/in_last/in_ready,
//        out_valid/out_data/out_last/out_ready and the gnt/gnt_id/busy status outputs.
module rr_bus_arbiter_8 #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_bus_arbiter_8_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   gnt_id_q, gnt_id_d;
    logic [2:0]   ptr_q, ptr_d;

    logic         win_vld;
    logic [2:0]   win_id;
    logic [2:0]   cand;
    logic [WIDTH-1:0] sel_data;

    // Round-robin search: first requester at or above ptr, wrapping 7->0.
    // The 3-bit add wraps naturally.
    always_comb begin
        win_vld = 1'b0;
        win_id  = 3'd0;
        cand    = 3'd0;
        for (int k = 0; k < 8; k++) begin
            cand = ptr_q + 3'(k);
            if (!win_vld && bus.in_req[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    // Data mux with constant slice indices keyed on the held grant.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (gnt_id_q == 3'(i)) begin
                sel_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_id_d      = gnt_id_q;
        ptr_d         = ptr_q;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        bus.in_ready  = 8'd0;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d  = BUSY;
                    gnt_id_d = win_id;
                end
            end
            BUSY: begin
                bus.out_valid = bus.in_req[gnt_id_q];
                bus.out_data  = sel_data;
                bus.out_last  = bus.in_last[gnt_id_q];
                bus.in_ready  = {7'd0, bus.out_ready} << gnt_id_q;
                // Grant is released only by an accepted last beat; a requester
                // that drops in_req mid-packet keeps the channel.
                if (bus.out_valid && bus.out_ready && bus.out_last) begin
                    state_d  = IDLE;
                    gnt_id_d = 3'd0;
                    ptr_d    = gnt_id_q + 3'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_id_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_id_q <= 3'd0;
            ptr_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
        end
    end

    // gnt_id_q is cleared on every return to IDLE, so it already reads 0 when idle.
    assign bus.busy   = (state_q == BUSY);
    assign bus.gnt_id = gnt_id_q;
    assign bus.gnt    = (state_q == BUSY) ? (8'd1 << gnt_id_q) : 8'd0;

endmodule

// File: tb/tb_rr_bus_arbiter_8.sv
// Purpose: directed self-checking bench for rr_bus_arbiter_8.
// Latency: inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
// Backpressure: out_ready is driven per cycle by the directed sequence.
module tb_rr_bus_arbiter_8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [15:0] d [8];

    rr_bus_arbiter_8_if #(.WIDTH(16)) bus ();

    rr_bus_arbiter_8 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.in_data = '0;
        for (int i = 0; i < 8; i++) begin
            bus.in_data[i*16 +: 16] = d[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        int c;
        logic rdy;
        logic req2;

        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_req    = 8'd0;
        bus.in_last   = 8'd0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) d[i] = 16'd0;

        // ---- reset then idle ----
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_gnt", 32'(bus.gnt), 32'd0);
            chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
            next_cycle();
        end

        // ---- single requester 3, three beats ----
        bus.in_req    = 8'h08;
        bus.out_ready = 1'b1;
        d[3]          = 16'hA001;
        @(negedge clk);
        chk("single_arb_busy", 32'(bus.busy), 32'd0);
        chk("single_arb_in_ready", 32'(bus.in_ready), 32'd0);
        chk("single_arb_out_data", 32'(bus.out_data), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("single_gnt", 32'(bus.gnt), 32'h08);
        chk("single_gnt_id", 32'(bus.gnt_id), 32'd3);
        chk("single_in_ready", 32'(bus.in_ready), 32'h08);
        chk("single_beat1", 32'(bus.out_data), 32'hA001);
        chk("single_last1", 32'(bus.out_last), 32'd0);
        next_cycle();
        d[3] = 16'hA002;
        @(negedge clk);
        chk("single_beat2", 32'(bus.out_data), 32'hA002);
        chk("single_valid2", 32'(bus.out_valid), 32'd1);
        next_cycle();
        d[3]        = 16'hA003;
        bus.in_last = 8'h08;
        @(negedge clk);
        chk("single_beat3", 32'(bus.out_data), 32'hA003);
        chk("single_last3", 32'(bus.out_last), 32'd1);
        next_cycle();
        // Pointer should now be 4: with 3 and 4 both requesting, 4 wins.
        bus.in_req  = 8'h18;
        bus.in_last = 8'h18;
        d[4]        = 16'hB004;
        @(negedge clk);
        chk("single_gap_busy", 32'(bus.busy), 32'd0);
        chk("single_gap_out_valid", 32'(bus.out_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("ptr4_gnt_id", 32'(bus.gnt_id), 32'd4);
        chk("ptr4_data", 32'(bus.out_data), 32'hB004);
        next_cycle();
        bus.in_req = 8'h00;
        @(negedge clk);
        chk("ptr4_done_busy", 32'(bus.busy), 32'd0);

        // ---- fairness from ptr=0 ----
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n       = 1'b1;
        bus.in_req  = 8'hFF;
        bus.in_last = 8'hFF;
        for (int i = 0; i < 8; i++) d[i] = 16'hF000 + 16'(i);
        @(negedge clk);
        chk("fair_start_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            @(negedge clk);
            chk("fair_gnt_id", 32'(bus.gnt_id), 32'(i % 8));
            chk("fair_gnt", 32'(bus.gnt), 32'(8'd1 << (i % 8)));
            chk("fair_data", 32'(bus.out_data), 32'(16'hF000 + 16'(i % 8)));
            next_cycle();
            @(negedge clk);
            chk("fair_gap_busy", 32'(bus.busy), 32'd0);
        end

        // ---- wrap-around: grant 5, then 8'h21 picks 0 ----
        bus.in_req = 8'h20;
        next_cycle();
        @(negedge clk);
        chk("wrap_gnt5", 32'(bus.gnt_id), 32'd5);
        bus.in_req = 8'h21;
        next_cycle();
        @(negedge clk);
        chk("wrap_gap_busy", 32'(bus.busy), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("wrap_gnt_id", 32'(bus.gnt_id), 32'd0);
        chk("wrap_gnt", 32'(bus.gnt), 32'h01);
        next_cycle();
        bus.in_req = 8'h00;
        @(negedge clk);
        chk("wrap_done_busy", 32'(bus.busy), 32'd0);

        // ---- backpressure and gaps on requester 2, requester 7 waiting ----
        bus.in_req    = 8'h04;
        bus.in_last   = 8'h00;
        bus.out_ready = 1'b1;
        d[2]          = 16'hC001;
        next_cycle();
        b = 0;
        c = 0;
        while (b < 4 && c < 30) begin
            rdy           = (c % 2 == 0);
            req2          = !(c == 2 || c == 3);
            bus.out_ready = rdy;
            bus.in_req    = {1'b1, 4'b0000, req2, 2'b00};
            bus.in_last   = {1'b1, 4'b0000, (b == 3), 2'b00};
            d[2]          = 16'hC001 + 16'(b);
            @(negedge clk);
            chk("bp_gnt", 32'(bus.gnt), 32'h04);
            chk("bp_in_ready", 32'(bus.in_ready), rdy ? 32'h04 : 32'h00);
            chk("bp_out_valid", 32'(bus.out_valid), 32'(req2));
            if (req2) begin
                chk("bp_data", 32'(bus.out_data), 32'(16'hC001 + 16'(b)));
                chk("bp_last", 32'(bus.out_last), 32'(b == 3));
            end
            if (req2 && rdy) b++;
            next_cycle();
            c++;
        end
        chk("bp_beats", 32'(b), 32'd4);
        chk("bp_cycles", 32'(c), 32'd9);
        bus.in_req    = 8'h80;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_gap_busy", 32'(bus.busy), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("bp_then_gnt7", 32'(bus.gnt), 32'h80);
        next_cycle();

        // ---- reset mid-packet ----
        // Single beat from 3 moves ptr to 4, then 5 is granted with 5 beats.
        bus.in_req  = 8'h08;
        bus.in_last = 8'h08;
        next_cycle();
        next_cycle();
        bus.in_req  = 8'h20;
        bus.in_last = 8'h00;
        d[5]        = 16'hD001;
        next_cycle();
        @(negedge clk);
        chk("mid_gnt5", 32'(bus.gnt_id), 32'd5);
        next_cycle();
        d[5] = 16'hD002;
        @(negedge clk);
        chk("mid_beat2", 32'(bus.out_data), 32'hD002);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
        next_cycle();
        bus.in_req  = 8'h81;
        bus.in_last = 8'h81;
        d[0]        = 16'hE000;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_post_busy", 32'(bus.busy), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("mid_post_gnt_id", 32'(bus.gnt_id), 32'd0);
        chk("mid_post_gnt", 32'(bus.gnt), 32'h01);
        chk("mid_post_data", 32'(bus.out_data), 32'hE000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_bus_arbiter_8.md
# rr_bus_arbiter_8

Round-robin arbiter sharing one WIDTH-bit output channel among eight requesters. It grants one requester at a time, holds the grant for a whole packet (until the beat flagged `last` is accepted downstream), then moves fairness priority past the winner. It sits in front of the 8:1 datapath mux and 8→3 priority-encode logic and drives their select and valid controls.

## Interface
- `WIDTH`, 16, data width per requester and of the output channel.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_req`  in  8  per-requester valid/request.
- `in_data`  in  8*WIDTH  requester i data at bits `[i*WIDTH +: WIDTH]`.
- `in_last`  in  8  per-requester end-of-packet flag, meaningful when `in_req[i]`=1.
- `in_ready`  out  8  per-requester accept; a beat from i transfers when `in_req[i] & in_ready[i]`.
- `out_valid`  out  1  output beat valid.
- `out_data`  out  WIDTH  output beat data.
- `out_last`  out  1  output end-of-packet.
- `out_ready`  in  1  downstream accept.
- `gnt`  out  8  one-hot current grant; 0 when idle.
- `gnt_id`  out  3  index of the current grant; 0 when idle.
- `busy`  out  1  1 while a grant is held.

## Operation
- Two states: IDLE and BUSY. Registered state: `busy`, `gnt_id`, and a 3-bit round-robin pointer `ptr`.
- Reset (`rst_n`=0, async): state IDLE, `ptr`=0, `gnt`=0, `gnt_id`=0, `busy`=0. All combinational outputs then evaluate to 0.
- IDLE, `in_req`≠0: the winner is the first set bit of `in_req`, searched upward from index `ptr` and wrapping 7→0. Register `gnt_id`=winner and `busy`=1, then go to BUSY.
- IDLE, `in_req`=0: stay in IDLE.
- BUSY, combinational outputs with g=`gnt_id`:
  - `out_valid`=`in_req[g]`, `out_data`=slot g, `out_last`=`in_last[g]`.
  - `in_ready[g]`=`out_ready`; all other `in_ready` bits are 0.
- IDLE: `out_valid`=0, `out_last`=0, `out_data`=0, `in_ready`=0.
- Transfer = `out_valid & out_ready`. A transfer with `out_last`=1 returns the block to IDLE on the next edge and sets `ptr`=(g+1) mod 8.
- If the granted requester drops `in_req` mid-packet, the grant is held and `out_valid` stays 0 until it resumes. There is no preemption and no timeout.
- Requests from non-granted requesters while BUSY are ignored; they are served only through the next IDLE arbitration.
- `gnt`=`busy` ? (1<<`gnt_id`) : 0.

## Timing
- Arbitration latency: a request first seen in IDLE at edge N gives `gnt`/`busy` valid after edge N. The first beat can transfer in that same cycle.
- Last beat accepted at edge M: IDLE after M. The next grant follows at edge M+1 at the earliest. There is always exactly one idle cycle between packets.
- Single-beat packet (`in_last`=1 on the first beat) holds the grant for exactly one cycle when `out_ready`=1.
- Data path is combinational from inputs to `out_*`, with no added latency. `out_ready`→`in_ready` is combinational.
- Simultaneous requests at arbitration: the round-robin order from `ptr` decides, with no other tie-break.
- Reset asserted mid-packet: returns to IDLE immediately. The in-flight packet is truncated; downstream is responsible for recovery.

## Test plan
- Reset then idle: `rst_n` 0→1, `in_req`=0 for 10 cycles -> `busy`=0, `gnt`=0, `out_valid`=0 throughout.
- Single requester: `in_req`=8'h08, 3-beat packet 16'hA001/A002/A003 (last on 3rd), `out_ready`=1 -> `gnt`=8'h08, `gnt_id`=3, three beats in order with `out_last` on A003, then IDLE for one cycle, `ptr`=4.
- Fairness: `in_req`=8'hFF constant, all packets single-beat, starting from `ptr`=0 -> grant order 0,1,…,7,0, one grant every 2 cycles.
- Wrap-around: `ptr`=6 (after a grant to 5), `in_req`=8'h21 -> grant 0 before 5.
- Backpressure and gaps: granted requester 2 sends 4 beats; `out_ready` toggles 1010…; `in_req[2]` drops for 2 cycles mid-packet while `in_req[7]`=1 -> grant stays on 2, `in_ready[7]`=0 throughout, exactly 4 beats delivered in order, then grant 7.
- Reset mid-packet: assert `rst_n`=0 during beat 2 of 5 -> outputs 0 asynchronously, `ptr`=0. After release with `in_req`=8'h81, grant goes to 0.
